// File: rtl/mem_line_engine_if.sv
// Bundle of cache-request and memory-word-port signals for mem_line_engine.
//   master : engine view (accepts line requests, initiates memory words)
//   slave  : environment view (cache controller + main memory)
// Request side : REQ_VALID/REQ_READY/REQ_WB/REQ_FILL, WB_LINE_ADDR, FILL_LINE_ADDR,
//                WB_DATA, FILL_DATA, DONE, BUSY
// Memory side  : MEM_RE, MEM_WE, MEM_ADDR, MEM_DATA_IN, MEM_DOUT, memValid
interface mem_line_engine_if #(
  parameter int unsigned LINE_WORDS_LOG2 = 3
);
  localparam int unsigned W  = 2 ** LINE_WORDS_LOG2;
  localparam int unsigned LA = 30 - LINE_WORDS_LOG2;

  logic              REQ_VALID;
  logic              REQ_READY;
  logic              REQ_WB;
  logic              REQ_FILL;
  logic [LA-1:0]     WB_LINE_ADDR;
  logic [LA-1:0]     FILL_LINE_ADDR;
  logic [32*W-1:0]   WB_DATA;
  logic [32*W-1:0]   FILL_DATA;
  logic              DONE;
  logic              BUSY;
  logic              MEM_RE;
  logic              MEM_WE;
  logic [29:0]       MEM_ADDR;
  logic [31:0]       MEM_DATA_IN;
  logic [31:0]       MEM_DOUT;
  logic              memValid;

  modport master (
    input  REQ_VALID, REQ_WB, REQ_FILL, WB_LINE_ADDR, FILL_LINE_ADDR, WB_DATA,
    input  MEM_DOUT, memValid,
    output REQ_READY, FILL_DATA, DONE, BUSY,
    output MEM_RE, MEM_WE, MEM_ADDR, MEM_DATA_IN
  );

  modport slave (
    output REQ_VALID, REQ_WB, REQ_FILL, WB_LINE_ADDR, FILL_LINE_ADDR, WB_DATA,
    output MEM_DOUT, memValid,
    input  REQ_READY, FILL_DATA, DONE, BUSY,
    input  MEM_RE, MEM_WE, MEM_ADDR, MEM_DATA_IN
  );
endinterface

// File: rtl/mem_line_engine.sv
// mem_line_engine: turns one cache-line request into single-word memory
// transactions -- optional victim writeback followed by optional line fill.
// Paced only by memValid; no knowledge of memory latency.
// Ports:
//   CLK    : clock, all state on posedge
//   RST_N  : asynchronous active-low reset
//   bus    : mem_line_engine_if.master (request handshake, line data,
//            DONE/BUSY status, memory word port)
module mem_line_engine #(
  parameter int unsigned LINE_WORDS_LOG2 = 3
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  mem_line_engine_if.master     bus
);
  localparam int unsigned W  = 2 ** LINE_WORDS_LOG2;
  localparam int unsigned LA = 30 - LINE_WORDS_LOG2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_DONE
  } state_t;

  state_t                     state;
  state_t                     state_nxt;
  logic [LINE_WORDS_LOG2-1:0] idx;
  logic                       wb_q;
  logic                       fill_q;
  logic [LA-1:0]              wb_addr_q;
  logic [LA-1:0]              fill_addr_q;
  logic [32*W-1:0]            wb_buf;
  logic [32*W-1:0]            fill_buf;
  logic                       accept;
  logic                       word_done;
  logic                       last_word;

  assign accept    = bus.REQ_VALID && (state == S_IDLE);
  // memValid only counts while a word is actually in flight
  assign word_done = bus.memValid && ((state == S_WB) || (state == S_FILL));
  assign last_word = &idx;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs depend on state and registers only, so reset drops the enables
  // asynchronously and memValid never reaches MEM_* combinationally.
  always_comb begin
    state_nxt       = state;
    bus.REQ_READY   = 1'b0;
    bus.BUSY        = 1'b1;
    bus.DONE        = 1'b0;
    bus.MEM_RE      = 1'b0;
    bus.MEM_WE      = 1'b0;
    bus.MEM_ADDR    = '0;
    bus.MEM_DATA_IN = '0;
    unique case (state)
      S_IDLE: begin
        bus.REQ_READY = 1'b1;
        bus.BUSY      = 1'b0;
        if (bus.REQ_VALID) begin
          if (bus.REQ_WB)        state_nxt = S_WB;
          else if (bus.REQ_FILL) state_nxt = S_FILL;
          else                   state_nxt = S_DONE;
        end
      end
      S_WB: begin
        bus.MEM_WE      = 1'b1;
        bus.MEM_ADDR    = {wb_addr_q, idx};
        bus.MEM_DATA_IN = wb_buf[{idx, 5'b0} +: 32];
        if (bus.memValid && last_word) state_nxt = fill_q ? S_FILL : S_DONE;
      end
      S_FILL: begin
        bus.MEM_RE   = 1'b1;
        bus.MEM_ADDR = {fill_addr_q, idx};
        if (bus.memValid && last_word) state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.DONE  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      idx         <= '0;
      wb_q        <= 1'b0;
      fill_q      <= 1'b0;
      wb_addr_q   <= '0;
      fill_addr_q <= '0;
      wb_buf      <= '0;
      fill_buf    <= '0;
    end else begin
      if (accept) begin
        wb_q        <= bus.REQ_WB;
        fill_q      <= bus.REQ_FILL;
        wb_addr_q   <= bus.WB_LINE_ADDR;
        fill_addr_q <= bus.FILL_LINE_ADDR;
        wb_buf      <= bus.WB_DATA;
      end
      // idx wraps to 0 on the last word, ready for the next phase
      if (word_done) begin
        idx <= idx + LINE_WORDS_LOG2'(1);
        if (state == S_FILL) fill_buf[{idx, 5'b0} +: 32] <= bus.MEM_DOUT;
      end
    end
  end

  assign bus.FILL_DATA = fill_buf;

endmodule
